// File: rtl/mem_pkg.sv
// Shared types for the LEGv8 memory stage: FSM states, NZVC flags and the
// EX/MEM and MEM/WB pipeline register payloads.
package mem_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned REG_AW = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } nzvc_t;

    typedef struct packed {
        logic              valid;
        logic              mem_we;
        logic              mem2reg;
        logic              reg_we;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   alu_out;
        logic [XLEN-1:0]   din;
    } exmem_t;

    typedef struct packed {
        logic              valid;
        logic              reg_we;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   dw;
    } memwb_t;

endpackage

// File: rtl/nzvc_flag_reg.sv
// Architectural NZVC flag register with load enable.
module nzvc_flag_reg
    import mem_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  load,
    input  nzvc_t d,
    output nzvc_t q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// LEGv8 memory stage: EX/MEM capture, req/ack data-memory access, NZVC and MEM/WB.
// Optional access timeout with sticky error is enabled by defining MEM_TIMEOUT_EN.
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_EX,
    input  logic              flush_EX,
    input  logic [XLEN-1:0]   ALU_out_EX,
    input  logic [XLEN-1:0]   Din_EX,
    input  logic              MemWE_EX,
    input  logic              Mem2Reg_EX,
    input  logic              RegWE_EX,
    input  logic [REG_AW-1:0] Rd_EX,
    input  logic              setFlag_EX,
    input  logic              ALU_neg,
    input  logic              ALUzeroFlag,
    input  logic              ALU_ov,
    input  logic              ALU_cout,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_ack,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              valid_WB,
    output logic [XLEN-1:0]   Dw_WB,
    output logic              RegWE_WB,
    output logic [REG_AW-1:0] Rd_WB,
    output logic              negFlag,
    output logic              zeroFlag,
    output logic              ovFlag,
    output logic              carryFlag,
    output logic              mem_err
);

    state_t state_q, state_d;
    exmem_t exmem_q, exmem_d;
    memwb_t memwb_q, memwb_d;
    nzvc_t  flags_d, flags_q;

    logic in_access;
    logic mem_op;
    logic cap_valid;
    logic cap_mem_op;
    logic done;
    logic timeout_hit;
    logic flag_load;

    assign in_access  = (state_q == ACCESS);
    assign mem_op     = exmem_q.valid & (exmem_q.mem_we | exmem_q.mem2reg);
    assign cap_valid  = valid_EX & ~flush_EX;
    assign cap_mem_op = cap_valid & (MemWE_EX | Mem2Reg_EX);
    assign done       = in_access & (dmem_ack | timeout_hit);
    assign stall      = in_access & ~done;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             mem_err_q;

    // Ack on the limit cycle takes priority over the timeout.
    assign timeout_hit = in_access & ~dmem_ack & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if ((state_d == ACCESS) && (!in_access || done)) begin
            cnt_q <= '0;
        end else if (in_access) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_err_q <= 1'b0;
        end else if (timeout_hit) begin
            mem_err_q <= 1'b1;
        end
    end

    assign mem_err = mem_err_q;
`else
    logic unused_cfg_c;

    assign unused_cfg_c = ^32'(TIMEOUT_CYCLES);
    assign timeout_hit  = 1'b0;
    assign mem_err      = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a completing access may chain directly into the next mem op
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cap_mem_op) state_d = ACCESS;
            ACCESS:  if (done)       state_d = cap_mem_op ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // EX/MEM capture; holds (and ignores flush) while stalled
    always_comb begin
        exmem_d = exmem_q;
        if (!stall) begin
            exmem_d.valid   = cap_valid;
            exmem_d.mem_we  = MemWE_EX;
            exmem_d.mem2reg = Mem2Reg_EX;
            exmem_d.reg_we  = RegWE_EX;
            exmem_d.rd      = Rd_EX;
            exmem_d.alu_out = ALU_out_EX;
            exmem_d.din     = Din_EX;
        end
    end

    // MEM/WB: ALU ops pass through, mem ops retire only on ack
    always_comb begin
        memwb_d        = memwb_q;
        memwb_d.valid  = 1'b0;
        memwb_d.reg_we = 1'b0;
        if (exmem_q.valid && !mem_op) begin
            memwb_d.valid  = 1'b1;
            memwb_d.reg_we = exmem_q.reg_we;
            memwb_d.rd     = exmem_q.rd;
            memwb_d.dw     = exmem_q.alu_out;
        end else if (mem_op && in_access && dmem_ack) begin
            memwb_d.valid = 1'b1;
            memwb_d.rd    = exmem_q.rd;
            if (exmem_q.mem2reg && !exmem_q.mem_we) begin
                memwb_d.reg_we = exmem_q.reg_we;
                memwb_d.dw     = dmem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign flag_load = cap_valid & setFlag_EX & ~stall;
    assign flags_d   = '{n: ALU_neg, z: ALUzeroFlag, v: ALU_ov, c: ALU_cout};

    nzvc_flag_reg u_flags (
        .clk   (clk),
        .reset (reset),
        .load  (flag_load),
        .d     (flags_d),
        .q     (flags_q)
    );

    assign negFlag    = flags_q.n;
    assign zeroFlag   = flags_q.z;
    assign ovFlag     = flags_q.v;
    assign carryFlag  = flags_q.c;

    assign dmem_req   = in_access;
    assign dmem_we    = in_access & exmem_q.mem_we;
    assign dmem_addr  = exmem_q.alu_out;
    assign dmem_wdata = exmem_q.din;

    assign valid_WB   = memwb_q.valid;
    assign RegWE_WB   = memwb_q.reg_we;
    assign Rd_WB      = memwb_q.rd;
    assign Dw_WB      = memwb_q.dw;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (timeout section active with MEM_TIMEOUT_EN).
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_EX, flush_EX;
    logic [63:0] ALU_out_EX, Din_EX;
    logic        MemWE_EX, Mem2Reg_EX, RegWE_EX;
    logic [4:0]  Rd_EX;
    logic        setFlag_EX, ALU_neg, ALUzeroFlag, ALU_ov, ALU_cout;
    logic        stall, dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;
    logic        valid_WB;
    logic [63:0] Dw_WB;
    logic        RegWE_WB;
    logic [4:0]  Rd_WB;
    logic        negFlag, zeroFlag, ovFlag, carryFlag, mem_err;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .valid_EX(valid_EX), .flush_EX(flush_EX),
        .ALU_out_EX(ALU_out_EX), .Din_EX(Din_EX),
        .MemWE_EX(MemWE_EX), .Mem2Reg_EX(Mem2Reg_EX), .RegWE_EX(RegWE_EX),
        .Rd_EX(Rd_EX), .setFlag_EX(setFlag_EX),
        .ALU_neg(ALU_neg), .ALUzeroFlag(ALUzeroFlag), .ALU_ov(ALU_ov), .ALU_cout(ALU_cout),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .valid_WB(valid_WB), .Dw_WB(Dw_WB), .RegWE_WB(RegWE_WB), .Rd_WB(Rd_WB),
        .negFlag(negFlag), .zeroFlag(zeroFlag), .ovFlag(ovFlag), .carryFlag(carryFlag),
        .mem_err(mem_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        valid_EX = 0; flush_EX = 0; ALU_out_EX = '0; Din_EX = '0;
        MemWE_EX = 0; Mem2Reg_EX = 0; RegWE_EX = 0; Rd_EX = '0;
        setFlag_EX = 0; ALU_neg = 0; ALUzeroFlag = 0; ALU_ov = 0; ALU_cout = 0;
    endtask

    task automatic issue_load(input logic [63:0] addr, input logic [4:0] rd);
        clear_ex();
        valid_EX = 1; Mem2Reg_EX = 1; RegWE_EX = 1; ALU_out_EX = addr; Rd_EX = rd;
    endtask

    initial begin
        reset = 0; dmem_ack = 0; dmem_rdata = '0;
        clear_ex();

        // reset state
        tick(); tick();
        chk("rst_req", 64'(dmem_req), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_valid_wb", 64'(valid_WB), 64'd0);
        chk("rst_nzvc", 64'({negFlag, zeroFlag, ovFlag, carryFlag}), 64'd0);
        chk("rst_mem_err", 64'(mem_err), 64'd0);
        chk("rst_dw", Dw_WB, 64'd0);
        reset = 1;
        tick();

        // ADD x3 = 0x10
        valid_EX = 1; ALU_out_EX = 64'h10; RegWE_EX = 1; Rd_EX = 5'd3;
        tick();
        clear_ex();
        chk("add_stall", 64'(stall), 64'd0);
        chk("add_valid_e1", 64'(valid_WB), 64'd0);
        tick();
        chk("add_valid_wb", 64'(valid_WB), 64'd1);
        chk("add_dw", Dw_WB, 64'h10);
        chk("add_rd", 64'(Rd_WB), 64'd3);
        chk("add_regwe", 64'(RegWE_WB), 64'd1);
        chk("add_stall2", 64'(stall), 64'd0);
        tick();
        chk("add_bubble", 64'(valid_WB), 64'd0);

        // LDUR x5,[0x40] acked on the 4th ACCESS cycle; ADD x7 waits behind it
        issue_load(64'h40, 5'd5);
        tick();
        clear_ex();
        valid_EX = 1; ALU_out_EX = 64'h77; RegWE_EX = 1; Rd_EX = 5'd7;
        for (int i = 0; i < 3; i++) begin
            chk("ld_stall", 64'(stall), 64'd1);
            chk("ld_req", 64'(dmem_req), 64'd1);
            chk("ld_we", 64'(dmem_we), 64'd0);
            chk("ld_addr", dmem_addr, 64'h40);
            chk("ld_valid_wb", 64'(valid_WB), 64'd0);
            tick();
        end
        dmem_ack = 1; dmem_rdata = 64'hDEAD;
        #1;
        chk("ld_stall_ack", 64'(stall), 64'd0);
        chk("ld_addr_ack", dmem_addr, 64'h40);
        tick();
        dmem_ack = 0; dmem_rdata = '0;
        clear_ex();
        chk("ld_valid_wb_done", 64'(valid_WB), 64'd1);
        chk("ld_dw", Dw_WB, 64'hDEAD);
        chk("ld_rd", 64'(Rd_WB), 64'd5);
        chk("ld_regwe", 64'(RegWE_WB), 64'd1);
        chk("ld_req_off", 64'(dmem_req), 64'd0);
        tick();
        chk("held_add_valid", 64'(valid_WB), 64'd1);
        chk("held_add_dw", Dw_WB, 64'h77);
        chk("held_add_rd", 64'(Rd_WB), 64'd7);

        // STUR 0x55 -> [0x80], immediate ack
        valid_EX = 1; MemWE_EX = 1; Din_EX = 64'h55; ALU_out_EX = 64'h80;
        tick();
        clear_ex();
        dmem_ack = 1;
        #1;
        chk("st_req", 64'(dmem_req), 64'd1);
        chk("st_we", 64'(dmem_we), 64'd1);
        chk("st_wdata", dmem_wdata, 64'h55);
        chk("st_addr", dmem_addr, 64'h80);
        chk("st_stall", 64'(stall), 64'd0);
        tick();
        dmem_ack = 0;
        chk("st_valid_wb", 64'(valid_WB), 64'd1);
        chk("st_regwe", 64'(RegWE_WB), 64'd0);
        chk("st_req_off", 64'(dmem_req), 64'd0);
        chk("st_we_off", 64'(dmem_we), 64'd0);

        // SUBS sets Z,C; flushed SUBS must not touch flags
        valid_EX = 1; setFlag_EX = 1; RegWE_EX = 1; Rd_EX = 5'd1; ALU_out_EX = '0;
        ALUzeroFlag = 1; ALU_cout = 1;
        tick();
        chk("subs_nzvc", 64'({negFlag, zeroFlag, ovFlag, carryFlag}), 64'b0101);
        flush_EX = 1; ALUzeroFlag = 0; ALU_cout = 0; ALU_neg = 1; ALU_ov = 1;
        tick();
        clear_ex();
        chk("flush_nzvc", 64'({negFlag, zeroFlag, ovFlag, carryFlag}), 64'b0101);
        chk("subs_valid_wb", 64'(valid_WB), 64'd1);
        tick();
        chk("flush_bubble", 64'(valid_WB), 64'd0);

        // reset in the middle of an unacked access
        issue_load(64'h200, 5'd9);
        tick();
        clear_ex();
        chk("mid_req_before", 64'(dmem_req), 64'd1);
        tick();
        reset = 0;
        #1;
        chk("mid_rst_req", 64'(dmem_req), 64'd0);
        chk("mid_rst_stall", 64'(stall), 64'd0);
        chk("mid_rst_valid_wb", 64'(valid_WB), 64'd0);
        chk("mid_rst_nzvc", 64'({negFlag, zeroFlag, ovFlag, carryFlag}), 64'd0);
        tick();
        reset = 1;
        tick();

`ifdef MEM_TIMEOUT_EN
        // load never acked: aborts after 4 ACCESS cycles
        issue_load(64'h100, 5'd4);
        tick();
        clear_ex();
        for (int i = 0; i < 4; i++) begin
            chk("to_req", 64'(dmem_req), 64'd1);
            if (i < 3) chk("to_stall", 64'(stall), 64'd1);
            tick();
        end
        chk("to_req_off", 64'(dmem_req), 64'd0);
        chk("to_mem_err", 64'(mem_err), 64'd1);
        chk("to_valid_wb", 64'(valid_WB), 64'd0);
        chk("to_stall_off", 64'(stall), 64'd0);
        tick();
        chk("to_valid_wb2", 64'(valid_WB), 64'd0);
        chk("to_err_sticky", 64'(mem_err), 64'd1);

        reset = 0; tick(); reset = 1; tick();

        // ack on the limit cycle completes normally
        issue_load(64'h108, 5'd6);
        tick();
        clear_ex();
        for (int i = 0; i < 3; i++) tick();
        dmem_ack = 1; dmem_rdata = 64'hBEEF;
        tick();
        dmem_ack = 0; dmem_rdata = '0;
        chk("lim_valid_wb", 64'(valid_WB), 64'd1);
        chk("lim_dw", Dw_WB, 64'hBEEF);
        chk("lim_mem_err", 64'(mem_err), 64'd0);
        chk("lim_req_off", 64'(dmem_req), 64'd0);
`else
        chk("no_to_mem_err", 64'(mem_err), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
